// File: rtl/dcache_lsu.sv
// Load/store sequencer between the memory stage and the data cache: one op in flight,
// alignment check, level-held cache request until hit, load-data alignment and extension.
module dcache_lsu #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic                  req_wrn,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   input  logic                  kill,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [TAG_WIDTH-1:0]  resp_tag,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] dc_addr,
   output logic [DATA_WIDTH-1:0] dc_wdata,
   output logic [1:0]            dc_wlen,
   output logic                  dc_enable,
   output logic                  dc_wrn,
   input  logic [DATA_WIDTH-1:0] dc_rdata,
   input  logic                  dc_valid,
   input  logic                  dc_write_done,
   output logic [CNT_WIDTH-1:0]  stall_cycles
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic                  wrn_q, wrn_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;

   logic [2:0]            align_mask;
   logic                  misaligned;
   logic                  hit;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] load_ext;

   always_comb begin
      align_mask = 3'b000;
      case (req_size)
         2'd0: align_mask = 3'b000;
         2'd1: align_mask = 3'b001;
         2'd2: align_mask = 3'b011;
         2'd3: align_mask = 3'b111;
         default: align_mask = 3'b000;
      endcase
      misaligned = |(req_addr[2:0] & align_mask);
   end

   assign hit     = wrn_q ? dc_write_done : dc_valid;
   assign shifted = dc_rdata >> {addr_q[2:0], 3'b000};

   // Sign comes from the top kept bit; a full-word load has nothing to extend.
   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'd0: load_ext = {{(DATA_WIDTH-8){shifted[7] & ~uns_q}}, shifted[7:0]};
         2'd1: load_ext = {{(DATA_WIDTH-16){shifted[15] & ~uns_q}}, shifted[15:0]};
         2'd2: load_ext = {{(DATA_WIDTH-32){shifted[31] & ~uns_q}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      uns_d       = uns_q;
      wrn_d       = wrn_q;
      tag_d       = tag_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      stall_d     = stall_q;
      case (state_q)
         IDLE: begin
            // A kill on the acceptance cycle squashes loads only; stores always proceed.
            if (req_valid && !(kill && !req_wrn)) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wrn_d   = req_wrn;
               tag_d   = req_tag;
               if (misaligned) begin
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
                  state_d     = RESP;
               end else begin
                  resp_err_d = 1'b0;
                  state_d    = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!hit && (stall_q != {CNT_WIDTH{1'b1}})) begin
               stall_d = stall_q + 1'b1;
            end
            if (kill && !wrn_q) begin
               state_d = IDLE;
            end else if (hit) begin
               resp_data_d = wrn_q ? '0 : load_ext;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         wrn_q       <= 1'b0;
         tag_q       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         wrn_q       <= wrn_d;
         tag_q       <= tag_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         stall_q     <= stall_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign resp_valid   = (state_q == RESP);
   assign dc_enable    = (state_q == ACCESS);
   assign dc_addr      = addr_q;
   assign dc_wdata     = wdata_q;
   assign dc_wlen      = size_q;
   assign dc_wrn       = wrn_q;
   assign resp_data    = resp_data_q;
   assign resp_err     = resp_err_q;
   assign resp_tag     = tag_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dcache_lsu.sv
// Directed bench for dcache_lsu: loads, stores, misalignment, kill, backpressure, async reset.
module tb_dcache_lsu;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        req_wrn;
   logic [4:0]  req_tag;
   logic        kill;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_tag;
   logic        resp_err;
   logic [63:0] dc_addr;
   logic [63:0] dc_wdata;
   logic [1:0]  dc_wlen;
   logic        dc_enable;
   logic        dc_wrn;
   logic [63:0] dc_rdata;
   logic        dc_valid;
   logic        dc_write_done;
   logic [31:0] stall_cycles;

   int n_tests;
   int n_fail;

   dcache_lsu dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wrn(req_wrn), .req_tag(req_tag), .kill(kill),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_err(resp_err),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wlen(dc_wlen),
      .dc_enable(dc_enable), .dc_wrn(dc_wrn), .dc_rdata(dc_rdata),
      .dc_valid(dc_valid), .dc_write_done(dc_write_done),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%016h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [63:0] addr, input logic [63:0] wdata, input logic [1:0] size,
                          input logic uns, input logic wrn, input logic [4:0] tag);
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      req_wrn      = wrn;
      req_tag      = tag;
      req_valid    = 1'b1;
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("rel_req_ready", req_ready, 1'b1);
      chk("rel_resp_valid", resp_valid, 1'b0);
   endtask

   // Load that hits on its first ACCESS cycle.
   task automatic do_load(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                          input logic [63:0] word, input logic [4:0] tag, input logic [63:0] exp);
      present(addr, 64'h0, size, uns, 1'b0, tag);
      tick();
      req_valid = 1'b0;
      chk("ld_dc_enable", dc_enable, 1'b1);
      chk("ld_resp_valid_early", resp_valid, 1'b0);
      chk("ld_dc_addr", dc_addr, addr);
      chk("ld_dc_wrn", dc_wrn, 1'b0);
      dc_rdata = word;
      dc_valid = 1'b1;
      tick();
      dc_valid = 1'b0;
      chk("ld_resp_valid", resp_valid, 1'b1);
      chk("ld_resp_data", resp_data, exp);
      chk("ld_resp_err", resp_err, 1'b0);
      chk("ld_resp_tag", resp_tag, tag);
      chk("ld_dc_enable_off", dc_enable, 1'b0);
      take_resp();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
      req_unsigned = 1'b0; req_wrn = 1'b0; req_tag = '0; kill = 1'b0;
      resp_ready = 1'b0; dc_rdata = '0; dc_valid = 1'b0; dc_write_done = 1'b0;
      #12;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_dc_enable", dc_enable, 1'b0);
      chk("rst_resp_data", resp_data, 64'h0);
      chk("rst_stall", stall_cycles, 64'h0);
      reset_n = 1'b1;
      tick();

      do_load(64'h1003, 2'd0, 1'b0, 64'h1122334455667788, 5'd3, 64'h0000000000000055);
      do_load(64'h1000, 2'd2, 1'b0, 64'h0000000080000000, 5'd4, 64'hFFFFFFFF80000000);
      do_load(64'h1000, 2'd2, 1'b1, 64'h0000000080000000, 5'd5, 64'h0000000080000000);
      do_load(64'h1006, 2'd1, 1'b0, 64'h8123000000000000, 5'd6, 64'hFFFFFFFFFFFF8123);
      chk("stall_after_hits", stall_cycles, 64'd0);

      // Misaligned load: straight to response with error.
      present(64'h3002, 64'h0, 2'd2, 1'b0, 1'b0, 5'd7);
      tick();
      req_valid = 1'b0;
      chk("mis_dc_enable", dc_enable, 1'b0);
      chk("mis_resp_valid", resp_valid, 1'b1);
      chk("mis_resp_err", resp_err, 1'b1);
      chk("mis_resp_data", resp_data, 64'h0);
      chk("mis_resp_tag", resp_tag, 5'd7);
      take_resp();

      // Store with write_done on the 4th ACCESS cycle.
      present(64'h2006, 64'hBEEF, 2'd1, 1'b0, 1'b1, 5'd9);
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("st_dc_enable_c%0d", i), dc_enable, 1'b1);
         chk($sformatf("st_dc_wlen_c%0d", i), dc_wlen, 2'd1);
         chk($sformatf("st_dc_wrn_c%0d", i), dc_wrn, 1'b1);
         if (i == 4) dc_write_done = 1'b1;
         tick();
         dc_write_done = 1'b0;
      end
      chk("st_dc_enable_off", dc_enable, 1'b0);
      chk("st_dc_wdata", dc_wdata, 64'hBEEF);
      chk("st_dc_addr", dc_addr, 64'h2006);
      chk("st_resp_valid", resp_valid, 1'b1);
      chk("st_resp_err", resp_err, 1'b0);
      chk("st_resp_data", resp_data, 64'h0);
      chk("st_resp_tag", resp_tag, 5'd9);
      chk("st_stall", stall_cycles, 64'd3);
      take_resp();

      // Load killed on its 2nd ACCESS cycle.
      present(64'h4000, 64'h0, 2'd3, 1'b0, 1'b0, 5'd10);
      tick();
      req_valid = 1'b0;
      chk("kl_dc_enable_c1", dc_enable, 1'b1);
      tick();
      chk("kl_dc_enable_c2", dc_enable, 1'b1);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kl_idle_req_ready", req_ready, 1'b1);
      chk("kl_dc_enable", dc_enable, 1'b0);
      chk("kl_resp_valid", resp_valid, 1'b0);
      chk("kl_stall", stall_cycles, 64'd5);
      tick();
      chk("kl_resp_valid_later", resp_valid, 1'b0);

      // Kill on the acceptance cycle drops a load.
      present(64'h4008, 64'h0, 2'd3, 1'b0, 1'b0, 5'd11);
      kill = 1'b1;
      tick();
      req_valid = 1'b0;
      kill = 1'b0;
      chk("kacc_ld_req_ready", req_ready, 1'b1);
      chk("kacc_ld_dc_enable", dc_enable, 1'b0);

      // Store with kill held throughout still completes.
      present(64'h4010, 64'h1234, 2'd3, 1'b0, 1'b1, 5'd12);
      kill = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("kst_dc_enable", dc_enable, 1'b1);
      dc_write_done = 1'b1;
      tick();
      dc_write_done = 1'b0;
      chk("kst_resp_valid", resp_valid, 1'b1);
      chk("kst_resp_tag", resp_tag, 5'd12);
      tick();
      chk("kst_resp_hold_under_kill", resp_valid, 1'b1);
      kill = 1'b0;
      take_resp();

      // Backpressure: response held while a new request waits.
      present(64'h5001, 64'h0, 2'd0, 1'b1, 1'b0, 5'd13);
      tick();
      dc_rdata = 64'h000000000000F000;
      dc_valid = 1'b1;
      tick();
      dc_valid = 1'b0;
      present(64'h6000, 64'h0, 2'd3, 1'b0, 1'b0, 5'd14);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_resp_valid_%0d", i), resp_valid, 1'b1);
         chk($sformatf("bp_req_ready_%0d", i), req_ready, 1'b0);
         chk($sformatf("bp_resp_data_%0d", i), resp_data, 64'h00000000000000F0);
         chk($sformatf("bp_resp_tag_%0d", i), resp_tag, 5'd13);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bp_release_resp_valid", resp_valid, 1'b0);
      chk("bp_release_dc_enable", dc_enable, 1'b0);
      chk("bp_release_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk("bp_next_dc_enable", dc_enable, 1'b1);
      chk("bp_next_dc_addr", dc_addr, 64'h6000);

      // Asynchronous reset mid-ACCESS.
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_dc_enable", dc_enable, 1'b0);
      chk("arst_resp_valid", resp_valid, 1'b0);
      chk("arst_stall", stall_cycles, 64'd0);
      #2;
      reset_n = 1'b1;
      tick();
      chk("arst_req_ready", req_ready, 1'b1);
      chk("arst_dc_enable_after", dc_enable, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
